bch_dec_ctrl: RTL and testbench
===============================

Name: bch_dec_ctrl

Overview:
- Top-level sequencer for the BCH decoder datapath: load → syndrome → Berlekamp (BER) → Chien search → output.
- Owns the `set`/`ready` input handshake and latches the per-codeword configuration (code length, t, mode).
- Pulses start to each stage, waits for its done, and applies watchdog and consistency checks.
- Drives the `finish`/output-index sequencing; the top muxes `odata` from the error-location buffer using `out_idx`.

Parameters:
- TIMEOUT, 2047: maximum cycles to wait for any stage done before declaring failure.
- CNT_W, 11: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- set  in  1  codeword start request, sampled in IDLE only
- mode  in  1  0 = hard decision, 1 = soft decision; latched with set
- code  in  2  1 = (63,51), 2 = (255,239), 3 = (1023,983); 0 is illegal
- ready  out  1  high while input beats are accepted
- beat_idx  out  7  index of current load beat (0-based)
- n_len  out  10  latched code length: 63 / 255 / 1023
- t_sel  out  3  latched correction capability: 2 / 2 / 4
- mode_q  out  1  latched mode
- syn_start  out  1  one-cycle pulse
- syn_done  in  1  syndrome stage complete
- syn_zero  in  1  all syndromes zero; valid with syn_done
- ber_start  out  1  one-cycle pulse
- ber_done  in  1  BER stage complete
- ber_deg  in  3  error-locator degree; valid with ber_done
- chien_start  out  1  one-cycle pulse
- chien_done  in  1  Chien stage complete
- chien_cnt  in  3  roots found; valid with chien_done
- finish  out  1  high during output cycles
- out_idx  out  3  location-buffer read index
- out_last  out  1  final output cycle
- dec_fail  out  1  uncorrectable / timeout flag; held with finish

Behaviour:
- Reset: state = IDLE. All outputs are 0, including `n_len`, `t_sel`, `mode_q`, `beat_idx` and the watchdog. An asserted `rst` in any state aborts immediately; no start pulse is emitted afterwards.
- States: IDLE, LOAD, SYN, BER, CHIEN, OUT.
- IDLE:
  - `set`=1 with `code`≠0 → latch `n_len`/`t_sel`/`mode_q` and go to LOAD.
  - `set` with `code`=0 is ignored.
  - `set` in any other state is ignored.
- LOAD:
  - `ready`=1 from the cycle after `set` is sampled, for exactly B consecutive cycles, where B = (`n_len`+1)/8 = 8 / 32 / 128.
  - `beat_idx` = 0..B-1, one per cycle; every `ready` cycle is one accepted beat (no stall).
  - On beat B-1: next state SYN, `ready`=0 the following cycle.
- Stage states (SYN, BER, CHIEN):
  - The entry cycle pulses the stage start for exactly 1 cycle and clears the watchdog.
  - Done is ignored in the entry cycle and sampled from entry+1 onward.
  - The watchdog increments each waiting cycle; reaching TIMEOUT → OUT with `dec_fail`=1.
- SYN done:
  - `syn_zero`=1 → OUT, K=0 (no errors).
  - else → BER.
- BER done:
  - `ber_deg` > `t_sel` or `ber_deg`=0 → OUT with fail.
  - else → CHIEN; `ber_deg` is latched as D.
- CHIEN done:
  - `chien_cnt`≠D → OUT with fail.
  - else → OUT, K = D.
- OUT:
  - `finish`=1 for max(K,1) cycles, `out_idx` = 0..max(K,1)-1.
  - `out_last`=1 in the final cycle, then IDLE.
  - With K=0 or fail: a single `finish` cycle, `out_idx`=0, `out_last`=1, `dec_fail` as determined.
- `dec_fail` is cleared on entering LOAD.
- The earliest next `set` is accepted in the cycle after `out_last`.
- Registers are updated only on state-relevant enables: the config latch updates on the IDLE→LOAD transition only.

Test Plan:
- code=1, set 1 cycle → `ready` high 8 cycles, `beat_idx` 0..7; `syn_start` pulses the cycle after the last beat; `n_len`=63, `t_sel`=2.
- code=3, `syn_done`/`syn_zero`=1 → no `ber_start`; single `finish` cycle with `out_last`=1 and `dec_fail`=0.
- code=2, `ber_deg`=2, `chien_cnt`=2 → `finish` 2 cycles, `out_idx` 0,1, `out_last` on idx 1, `dec_fail`=0.
- code=3, `ber_deg`=4, `chien_cnt`=3 → single `finish` cycle with `dec_fail`=1; next `set` clears `dec_fail` on LOAD.
- `ber_done` never asserted → `finish`+`dec_fail` exactly TIMEOUT+1 cycles after `ber_start`.
- Edge cases:
  - `rst` pulsed mid-LOAD (beat 5) → all outputs 0 asynchronously.
  - `set` during SYN ignored.
  - code=0 `set` ignored; `ready` stays 0.

Source files
------------

// File: rtl/bch_dec_ctrl.sv
// rtl/bch_dec_ctrl.sv - BCH decoder sequencer: load, syndrome, BER, Chien, output
// Latches per-codeword config, steps the stage handshakes and sequences the location-buffer readout.
module bch_dec_ctrl #(
  parameter int TIMEOUT = 2047,
  parameter int CNT_W   = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set,
  input  logic        mode,
  input  logic [1:0]  code,
  output logic        ready,
  output logic [6:0]  beat_idx,
  output logic [9:0]  n_len,
  output logic [2:0]  t_sel,
  output logic        mode_q,
  output logic        syn_start,
  input  logic        syn_done,
  input  logic        syn_zero,
  output logic        ber_start,
  input  logic        ber_done,
  input  logic [2:0]  ber_deg,
  output logic        chien_start,
  input  logic        chien_done,
  input  logic [2:0]  chien_cnt,
  output logic        finish,
  output logic [2:0]  out_idx,
  output logic        out_last,
  output logic        dec_fail
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SYN, S_BER, S_CHIEN, S_OUT} state_t;

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [6:0]       beat_q, beat_d;
  logic [CNT_W-1:0] wd_q, wd_d, wd_inc;
  logic             entry_q, entry_d;
  logic [2:0]       deg_q, deg_d;
  logic [2:0]       k_q, k_d, k_last;
  logic             fail_q, fail_d;
  logic [2:0]       oidx_q, oidx_d;
  logic [9:0]       n_len_q, n_len_d;
  logic [2:0]       t_sel_q, t_sel_d;
  logic             mode_d;
  logic             done_sel;

  assign wd_inc   = wd_q + CNT_W'(1);
  assign k_last   = (k_q == 3'd0) ? 3'd0 : k_q - 3'd1;
  assign done_sel = (state_q == S_SYN) ? syn_done :
                    (state_q == S_BER) ? ber_done : chien_done;

  assign syn_start   = entry_q && (state_q == S_SYN);
  assign ber_start   = entry_q && (state_q == S_BER);
  assign chien_start = entry_q && (state_q == S_CHIEN);
  assign beat_idx    = beat_q;
  assign n_len       = n_len_q;
  assign t_sel       = t_sel_q;
  assign out_idx     = oidx_q;
  assign dec_fail    = fail_q;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    wd_d     = wd_q;
    deg_d    = deg_q;
    k_d      = k_q;
    fail_d   = fail_q;
    oidx_d   = oidx_q;
    n_len_d  = n_len_q;
    t_sel_d  = t_sel_q;
    mode_d   = mode_q;
    ready    = 1'b0;
    finish   = 1'b0;
    out_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (set && code != 2'd0) begin
          state_d = S_LOAD;
          fail_d  = 1'b0;
          beat_d  = 7'd0;
          mode_d  = mode;
          case (code)
            2'd1:    begin n_len_d = 10'd63;   t_sel_d = 3'd2; end
            2'd2:    begin n_len_d = 10'd255;  t_sel_d = 3'd2; end
            default: begin n_len_d = 10'd1023; t_sel_d = 3'd4; end
          endcase
        end
      end
      S_LOAD: begin
        ready = 1'b1;
        // (n_len+1)/8 beats, so the last beat index is n_len/8
        if (beat_q == n_len_q[9:3]) begin
          beat_d  = 7'd0;
          state_d = S_SYN;
        end else begin
          beat_d = beat_q + 7'd1;
        end
      end
      S_SYN, S_BER, S_CHIEN: begin
        if (entry_q) begin
          wd_d = '0;
        end else if (done_sel) begin
          if (state_q == S_SYN) begin
            if (syn_zero) begin
              state_d = S_OUT;
              k_d     = 3'd0;
            end else begin
              state_d = S_BER;
            end
          end else if (state_q == S_BER) begin
            if (ber_deg == 3'd0 || ber_deg > t_sel_q) begin
              state_d = S_OUT;
              k_d     = 3'd0;
              fail_d  = 1'b1;
            end else begin
              state_d = S_CHIEN;
              deg_d   = ber_deg;
            end
          end else begin
            state_d = S_OUT;
            if (chien_cnt != deg_q) begin
              k_d    = 3'd0;
              fail_d = 1'b1;
            end else begin
              k_d = deg_q;
            end
          end
        end else if (wd_inc == TO) begin
          state_d = S_OUT;
          k_d     = 3'd0;
          fail_d  = 1'b1;
        end else begin
          wd_d = wd_inc;
        end
      end
      S_OUT: begin
        finish = 1'b1;
        if (oidx_q == k_last) begin
          out_last = 1'b1;
          oidx_d   = 3'd0;
          state_d  = S_IDLE;
        end else begin
          oidx_d = oidx_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    entry_d = (state_d != state_q) &&
              (state_d == S_SYN || state_d == S_BER || state_d == S_CHIEN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      wd_q    <= '0;
      entry_q <= 1'b0;
      deg_q   <= '0;
      k_q     <= '0;
      fail_q  <= 1'b0;
      oidx_q  <= '0;
      n_len_q <= '0;
      t_sel_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wd_q    <= wd_d;
      entry_q <= entry_d;
      deg_q   <= deg_d;
      k_q     <= k_d;
      fail_q  <= fail_d;
      oidx_q  <= oidx_d;
      n_len_q <= n_len_d;
      t_sel_q <= t_sel_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_bch_dec_ctrl.sv
// tb/tb_bch_dec_ctrl.sv - scoreboard bench for bch_dec_ctrl
// Expected load beats and output cycles are queued at stimulus time and popped by a negedge monitor.
module tb_bch_dec_ctrl;

  localparam int TO = 2047;

  logic       clk = 1'b0;
  logic       rst;
  logic       set, mode;
  logic [1:0] code;
  logic       ready;
  logic [6:0] beat_idx;
  logic [9:0] n_len;
  logic [2:0] t_sel;
  logic       mode_q;
  logic       syn_start, syn_done, syn_zero;
  logic       ber_start, ber_done;
  logic [2:0] ber_deg;
  logic       chien_start, chien_done;
  logic [2:0] chien_cnt;
  logic       finish;
  logic [2:0] out_idx;
  logic       out_last, dec_fail;

  bch_dec_ctrl #(.TIMEOUT(TO), .CNT_W(11)) dut (
    .clk(clk), .rst(rst), .set(set), .mode(mode), .code(code),
    .ready(ready), .beat_idx(beat_idx), .n_len(n_len), .t_sel(t_sel), .mode_q(mode_q),
    .syn_start(syn_start), .syn_done(syn_done), .syn_zero(syn_zero),
    .ber_start(ber_start), .ber_done(ber_done), .ber_deg(ber_deg),
    .chien_start(chien_start), .chien_done(chien_done), .chien_cnt(chien_cnt),
    .finish(finish), .out_idx(out_idx), .out_last(out_last), .dec_fail(dec_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int last;
    int fail;
  } fin_t;

  int   beat_exp[$];
  fin_t fin_exp[$];
  int   n_run = 0, n_fail = 0;
  int   n_syn = 0, n_ber = 0, n_chien = 0;
  int   cyc = 0, last_rdy = -100;
  bit   ps = 0, pb = 0, pc = 0;
  int   mon_e;
  fin_t mon_f;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic longint outs();
    return longint'({ready, beat_idx, n_len, t_sel, mode_q, syn_start, ber_start,
                     chien_start, finish, out_idx, out_last, dec_fail});
  endfunction

  task automatic wait_evt(input string tag, input int which, input int limit);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      case (which)
        0: ok = syn_start;
        1: ok = ber_start;
        2: ok = chien_start;
        default: ok = finish;
      endcase
      if (ok) break;
      tick();
    end
    if (!ok) chk(tag, 0, 1);
  endtask

  task automatic drain_finish();
    for (int i = 0; i < 12 && finish; i++) tick();
    chk("finish_end", finish, 0);
    tick();
  endtask

  // drive set, queue expected beats, check the latched config in the first LOAD cycle
  task automatic start_cw(input logic [1:0] c, input logic m);
    int b = (c == 2'd1) ? 8 : (c == 2'd2) ? 32 : 128;
    for (int i = 0; i < b; i++) beat_exp.push_back(i);
    set = 1'b1; code = c; mode = m;
    tick();
    set = 1'b0; code = 2'd0; mode = 1'b0;
    chk("n_len", n_len, (c == 2'd1) ? 63 : (c == 2'd2) ? 255 : 1023);
    chk("t_sel", t_sel, (c == 2'd3) ? 4 : 2);
    chk("mode_q", mode_q, m);
    wait_evt("syn_start_timeout", 0, b + 4);
  endtask

  task automatic run_cw(input logic [1:0] c, input logic m, input logic zero,
                        input int deg, input int cnt, input bit set_in_syn);
    int t = (c == 2'd3) ? 4 : 2;
    if (zero) fin_exp.push_back('{0, 1, 0});
    else if (deg == 0 || deg > t || cnt != deg) fin_exp.push_back('{0, 1, 1});
    else for (int i = 0; i < deg; i++) fin_exp.push_back('{i, (i == deg - 1) ? 1 : 0, 0});
    start_cw(c, m);
    if (set_in_syn) begin
      set = 1'b1; code = 2'd2; mode = ~m;
    end
    tick();
    set = 1'b0; code = 2'd0; mode = 1'b0;
    syn_done = 1'b1; syn_zero = zero;
    tick();
    syn_done = 1'b0; syn_zero = 1'b0;
    if (!zero) begin
      wait_evt("ber_start_timeout", 1, 8);
      tick();
      ber_done = 1'b1; ber_deg = 3'(deg);
      tick();
      ber_done = 1'b0; ber_deg = 3'd0;
      if (deg != 0 && deg <= t) begin
        wait_evt("chien_start_timeout", 2, 8);
        tick();
        chien_done = 1'b1; chien_cnt = 3'(cnt);
        tick();
        chien_done = 1'b0; chien_cnt = 3'd0;
      end
    end
    wait_evt("finish_timeout", 3, 8);
    drain_finish();
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      ps = 0; pb = 0; pc = 0;
    end else begin
      if (ready) begin
        chk("dec_fail_in_load", dec_fail, 0);
        if (beat_exp.size() == 0) chk("beat_extra", 1, 0);
        else begin
          mon_e = beat_exp.pop_front();
          chk("beat_idx", beat_idx, mon_e);
        end
        last_rdy = cyc;
      end
      if (syn_start) begin
        chk("syn_start_width", ps, 0);
        chk("syn_after_load", cyc - last_rdy, 1);
        n_syn++;
      end
      if (ber_start) begin
        chk("ber_start_width", pb, 0);
        n_ber++;
      end
      if (chien_start) begin
        chk("chien_start_width", pc, 0);
        n_chien++;
      end
      if (finish) begin
        if (fin_exp.size() == 0) chk("finish_extra", 1, 0);
        else begin
          mon_f = fin_exp.pop_front();
          chk("out_idx", out_idx, mon_f.idx);
          chk("out_last", out_last, mon_f.last);
          chk("dec_fail", dec_fail, mon_f.fail);
        end
      end
      ps = syn_start; pb = ber_start; pc = chien_start;
    end
  end

  initial begin
    int nb, nc, ns, cycles;
    rst = 1'b1; set = 1'b0; mode = 1'b0; code = 2'd0;
    syn_done = 1'b0; syn_zero = 1'b0; ber_done = 1'b0; ber_deg = 3'd0;
    chien_done = 1'b0; chien_cnt = 3'd0;
    repeat (2) tick();
    chk("reset_outs", outs(), 0);
    rst = 1'b0;
    tick();

    set = 1'b1; code = 2'd0;
    tick();
    set = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ready_code0", ready, 0);
      tick();
    end

    run_cw(2'd1, 1'b0, 1'b1, 0, 0, 1'b1);
    chk("n_len_hold", n_len, 63);
    chk("t_sel_hold", t_sel, 2);
    nb = n_ber;
    run_cw(2'd3, 1'b0, 1'b1, 0, 0, 1'b0);
    chk("no_ber_start", n_ber, nb);
    run_cw(2'd2, 1'b1, 1'b0, 2, 2, 1'b0);
    run_cw(2'd3, 1'b0, 1'b0, 4, 3, 1'b0);
    run_cw(2'd3, 1'b1, 1'b0, 4, 4, 1'b0);
    run_cw(2'd1, 1'b0, 1'b0, 3, 3, 1'b0);
    run_cw(2'd2, 1'b0, 1'b0, 0, 0, 1'b0);
    run_cw(2'd3, 1'b0, 1'b0, 1, 1, 1'b0);

    // BER done only in its entry cycle must be ignored, so the watchdog fires
    fin_exp.push_back('{0, 1, 1});
    nc = n_chien;
    start_cw(2'd1, 1'b0);
    tick();
    syn_done = 1'b1;
    tick();
    syn_done = 1'b0;
    wait_evt("ber_start_timeout", 1, 8);
    ber_done = 1'b1; ber_deg = 3'd1;
    cycles = 0;
    tick();
    cycles++;
    ber_done = 1'b0; ber_deg = 3'd0;
    while (!finish && cycles < TO + 20) begin
      tick();
      cycles++;
    end
    chk("timeout_latency", cycles, TO + 1);
    chk("no_chien_start", n_chien, nc);
    drain_finish();

    for (int i = 0; i < 32; i++) beat_exp.push_back(i);
    set = 1'b1; code = 2'd2;
    tick();
    set = 1'b0; code = 2'd0;
    for (int i = 0; i < 40 && beat_idx != 7'd5; i++) tick();
    chk("reached_beat5", beat_idx, 5);
    rst = 1'b1;
    #1;
    chk("async_reset_outs", outs(), 0);
    beat_exp.delete();
    tick();
    tick();
    rst = 1'b0;
    ns = n_syn;
    for (int i = 0; i < 40; i++) tick();
    chk("no_syn_after_reset", n_syn, ns);
    chk("idle_after_reset", outs(), 0);

    chk("beat_queue_empty", beat_exp.size(), 0);
    chk("fin_queue_empty", fin_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
